// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word size and
// rejection causes.
package dm_responder_pkg;

    localparam int DMR_WORD_BITS  = 32;
    localparam int DMR_WORD_BYTES = DMR_WORD_BITS / 8;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_e;

    // Why a request was rejected; kept encoded for a future status register.
    typedef enum logic [1:0] {
        DMR_ERR_NONE       = 2'd0,
        DMR_ERR_CONFLICT   = 2'd1,
        DMR_ERR_MISALIGNED = 2'd2,
        DMR_ERR_RANGE      = 2'd3
    } dmr_err_e;

    function automatic dmr_err_e dmr_classify(input logic       rd,
                                              input logic       wr,
                                              input logic [1:0] byte_offset,
                                              input logic       in_range);
        if (rd && wr)
            return DMR_ERR_CONFLICT;
        else if (byte_offset != 2'b00)
            return DMR_ERR_MISALIGNED;
        else if (!in_range)
            return DMR_ERR_RANGE;
        else
            return DMR_ERR_NONE;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Controller <-> data-memory request/response bundle.
interface dm_responder_if
    import dm_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
);

    logic                     enable_memaccess;
    logic                     do_dm_read;
    logic                     do_dm_write;
    logic [ADDR_WIDTH-1:0]    dm_address;
    logic [DMR_WORD_BITS-1:0] dm_write_data;
    logic [DMR_WORD_BITS-1:0] dm_read_data;
    logic                     dm_ready;
    logic                     dm_busy;
    logic                     dm_error;

    modport master (
        output enable_memaccess, do_dm_read, do_dm_write, dm_address, dm_write_data,
        input  dm_read_data, dm_ready, dm_busy, dm_error
    );

    modport slave (
        input  enable_memaccess, do_dm_read, do_dm_write, dm_address, dm_write_data,
        output dm_read_data, dm_ready, dm_busy, dm_error
    );

endinterface

// File: rtl/dm_responder_sram_array.sv
// Synchronous single-port word RAM; the read register only updates on a read,
// so the last read value is held across writes and idle cycles.
module dm_sram_array
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic [DMR_WORD_BITS-1:0] wdata,
    output logic [DMR_WORD_BITS-1:0] rdata
);

    logic [DMR_WORD_BITS-1:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset so it maps onto RAM macros; only the read register is cleared.
    always_ff @(posedge clock) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word access per request, inserts
// WAIT_STATES wait cycles, then pulses dm_ready for one cycle in RESP.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic           clock,
    input  logic           reset,
    dm_responder_if.slave  bus
);

    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam int         RAM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmr_state_e               state_q, state_d;
    logic [3:0]               count_q, count_d;
    logic [RAM_AW-1:0]        idx_q;
    logic [DMR_WORD_BITS-1:0] wdata_q;
    logic                     write_q;
    dmr_err_e                 err_q;

    logic [IDX_W-1:0]         req_idx;
    logic                     req_valid;
    logic                     req_in_range;
    dmr_err_e                 req_err;
    logic                     accept;

    logic                     ram_en;
    logic                     ram_we;
    logic [RAM_AW-1:0]        ram_addr;
    logic [DMR_WORD_BITS-1:0] ram_rdata;

    assign req_idx      = bus.dm_address[ADDR_WIDTH-1:2];
    assign req_valid    = bus.enable_memaccess && (bus.do_dm_read || bus.do_dm_write);
    assign req_in_range = (32'(req_idx) < 32'(DEPTH_WORDS));
    assign req_err      = dmr_classify(bus.do_dm_read, bus.do_dm_write,
                                       bus.dm_address[1:0], req_in_range);
    assign accept       = (state_q == DMR_IDLE) && req_valid && (req_err == DMR_ERR_NONE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = idx_q;
        case (state_q)
            DMR_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        // No wait cycles: the read must launch on the acceptance edge itself.
                        state_d  = DMR_RESP;
                        ram_en   = bus.do_dm_read;
                        ram_addr = req_idx[RAM_AW-1:0];
                    end else begin
                        state_d = DMR_WAIT;
                        count_d = WAIT_LOAD;
                    end
                end
            end
            DMR_WAIT: begin
                if (count_q == 4'd0) begin
                    state_d = DMR_RESP;
                    ram_en  = !write_q;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DMR_RESP: begin
                // Writes commit on the edge leaving RESP, ahead of any next acceptance.
                state_d = DMR_IDLE;
                ram_en  = write_q;
                ram_we  = write_q;
            end
            default: state_d = DMR_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= DMR_IDLE;
            count_q <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= DMR_ERR_NONE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= ((state_q == DMR_IDLE) && req_valid) ? req_err : DMR_ERR_NONE;
            if (accept) begin
                idx_q   <= req_idx[RAM_AW-1:0];
                wdata_q <= bus.dm_write_data;
                write_q <= bus.do_dm_write;
            end
        end
    end

    dm_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (RAM_AW)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.dm_read_data = ram_rdata;
    assign bus.dm_ready     = (state_q == DMR_RESP);
    assign bus.dm_busy      = (state_q != DMR_IDLE);
    assign bus.dm_error     = (err_q != DMR_ERR_NONE);

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances with WAIT_STATES 1, 0 and 3
// share clock and reset but have independent request buses.
module tb_dm_responder;

    localparam int AW    = 12;
    localparam int DEPTH = 512;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0]         en    = '0;
    logic [2:0]         rd    = '0;
    logic [2:0]         wr    = '0;
    logic [2:0][AW-1:0] addr  = '0;
    logic [2:0][31:0]   wdata = '0;
    wire  [2:0][31:0]   rdata;
    wire  [2:0]         ready;
    wire  [2:0]         busy;
    wire  [2:0]         err;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_responder_if #(.ADDR_WIDTH(AW)) bus ();

        assign bus.enable_memaccess = en[g];
        assign bus.do_dm_read       = rd[g];
        assign bus.do_dm_write      = wr[g];
        assign bus.dm_address       = addr[g];
        assign bus.dm_write_data    = wdata[g];
        assign rdata[g]             = bus.dm_read_data;
        assign ready[g]             = bus.dm_ready;
        assign busy[g]              = bus.dm_busy;
        assign err[g]               = bus.dm_error;

        dm_responder #(
            .DEPTH_WORDS (DEPTH),
            .ADDR_WIDTH  (AW),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    task automatic drive_req(input int i, input bit r, input bit w,
                             input logic [AW-1:0] a, input logic [31:0] d);
        en[i] = 1'b1; rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
    endtask

    task automatic clear_req(input int i);
        en[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    // Called just after a request is driven on a falling edge; returns at the
    // falling edge where dm_ready is seen, checking busy on every cycle.
    task automatic wait_ready(input int i, input int exp_lat, input string name);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            n_checks++;
            if (busy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy in cycle %0d: got %b, expected 1", name, c, busy[i]);
            end
            if (ready[i] === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s ready latency: got %0d, expected %0d (0 = timeout)", name, lat, exp_lat);
        end
    endtask

    task automatic access(input int i, input bit w, input logic [AW-1:0] a,
                          input logic [31:0] d, input string name, output logic [31:0] q);
        @(negedge clock);
        drive_req(i, !w, w, a, d);
        wait_ready(i, ws_of(i) + 1, name);
        q = rdata[i];
        clear_req(i);
        @(negedge clock);
        n_checks++;
        if (busy[i] !== 1'b0 || ready[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back to idle: busy=%b ready=%b, expected 0 0", name, busy[i], ready[i]);
        end
    endtask

    task automatic check_data(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s data: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic error_req(input int i, input bit r, input bit w, input logic [AW-1:0] a,
                             input logic [31:0] exp_rd, input string name);
        @(negedge clock);
        drive_req(i, r, w, a, 32'hFFFF_FFFF);
        @(negedge clock);
        clear_req(i);
        n_checks++;
        if (err[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s error pulse: got %b, expected 1", name, err[i]);
        end
        n_checks++;
        if (busy[i] !== 1'b0 || ready[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s no accept: busy=%b ready=%b, expected 0 0", name, busy[i], ready[i]);
        end
        check_data({name, " held"}, rdata[i], exp_rd);
        @(negedge clock);
        n_checks++;
        if (err[i] !== 1'b0 || ready[i] !== 1'b0 || busy[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after pulse: err=%b ready=%b busy=%b, expected 0 0 0",
                     name, err[i], ready[i], busy[i]);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #10;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rdata[i] !== 32'h0 || ready[i] !== 1'b0 || busy[i] !== 1'b0 || err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: rdata=%h ready=%b busy=%b err=%b, expected all 0",
                         i, rdata[i], ready[i], busy[i], err[i]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] q;
        access(0, 1'b1, 12'h010, 32'hDEAD_BEEF, "ws1 write 0x010", q);
        check_data("ws1 write leaves read_data", q, 32'h0);
        access(0, 1'b0, 12'h010, 32'h0, "ws1 read 0x010", q);
        check_data("ws1 read 0x010", q, 32'hDEAD_BEEF);
    endtask

    task automatic test_latency();
        logic [31:0] q;
        access(1, 1'b1, 12'h100, 32'h0000_0001, "ws0 write 0x100", q);
        access(1, 1'b0, 12'h100, 32'h0, "ws0 read 0x100", q);
        check_data("ws0 read 0x100", q, 32'h0000_0001);
        access(2, 1'b1, 12'h104, 32'hCAFE_F00D, "ws3 write 0x104", q);
        access(2, 1'b0, 12'h104, 32'h0, "ws3 read 0x104", q);
        check_data("ws3 read 0x104", q, 32'hCAFE_F00D);
    endtask

    task automatic test_conflict();
        logic [31:0] q;
        access(0, 1'b1, 12'h020, 32'h1111_2222, "write 0x020", q);
        error_req(0, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, "rd+wr 0x020");
        access(0, 1'b0, 12'h020, 32'h0, "read 0x020", q);
        check_data("0x020 unchanged", q, 32'h1111_2222);
    endtask

    task automatic test_misaligned_range();
        error_req(0, 1'b1, 1'b0, 12'h013, 32'h1111_2222, "misaligned 0x013");
        error_req(0, 1'b1, 1'b0, 12'h800, 32'h1111_2222, "range read 0x800");
        error_req(0, 1'b0, 1'b1, 12'h800, 32'h1111_2222, "range write 0x800");
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] q;
        access(2, 1'b1, 12'h040, 32'h0BAD_F00D, "ws3 write 0x040", q);
        @(negedge clock);
        drive_req(2, 1'b0, 1'b1, 12'h040, 32'h1234_5678);
        @(negedge clock);
        n_checks++;
        if (busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort write busy before reset: got %b, expected 1", busy[2]);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (rdata[2] !== 32'h0 || ready[2] !== 1'b0 || busy[2] !== 1'b0 || err[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset in wait: rdata=%h ready=%b busy=%b err=%b, expected all 0",
                     rdata[2], ready[2], busy[2], err[2]);
        end
        clear_req(2);
        @(negedge clock);
        reset = 1'b1;
        access(2, 1'b0, 12'h040, 32'h0, "read 0x040 after abort", q);
        check_data("0x040 keeps old value", q, 32'h0BAD_F00D);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        drive_req(0, 1'b0, 1'b1, 12'h080, 32'hA5A5_A5A5);
        wait_ready(0, 2, "b2b write 0x080");
        drive_req(0, 1'b1, 1'b0, 12'h080, 32'h0);
        @(negedge clock);
        n_checks++;
        if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b idle gap: busy=%b ready=%b, expected 0 0", busy[0], ready[0]);
        end
        @(negedge clock);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b read accepted: busy=%b, expected 1", busy[0]);
        end
        @(negedge clock);
        clear_req(0);
        n_checks++;
        if (ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b read ready: got %b, expected 1", ready[0]);
        end
        check_data("b2b read 0x080", rdata[0], 32'hA5A5_A5A5);
        @(negedge clock);
        n_checks++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b final idle: busy=%b, expected 0", busy[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_conflict();
        test_misaligned_range();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
